and_test: RTL and testbench

Bitwise AND unit for the binary-logic stage of the datapath. It has a zero-latency combinational `result = a & b` path. It also has a one-cycle registered copy of the same result with a valid flag, zero/all-ones flags and a popcount. An optional statistics block counts accepted operations.

---
 rtl/and_test.sv | 96 +++++++++
 tb/tb_and_test.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/and_test.sv
// Bitwise AND unit: combinational result plus a one-cycle registered copy with flags and popcount.
// Define AND_TEST_STATS_EN to add saturating op_count/zero_count statistics counters.
module and_test #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    localparam int ONES_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              in_valid,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_q,
    output logic              out_valid,
    output logic              zero_q,
    output logic              all_ones_q,
`ifdef AND_TEST_STATS_EN
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  zero_count,
`endif
    output logic [ONES_W-1:0] ones_q
);

    logic [WIDTH-1:0]  w_and;
    logic [ONES_W-1:0] w_ones;
    logic              w_zero;
    logic              w_all_ones;

    logic [WIDTH-1:0]  r_result;
    logic              r_valid;
    logic              r_zero;
    logic              r_all_ones;
    logic [ONES_W-1:0] r_ones;

    // Flags are derived from the same AND value that gets captured, so they never mix old and new data.
    assign w_and      = a & b;
    assign w_zero     = (w_and == '0);
    assign w_all_ones = (w_and == '1);

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ones = w_ones + ONES_W'(w_and[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_zero     <= 1'b1;
            r_all_ones <= 1'b0;
            r_ones     <= '0;
        end else if (in_valid) begin
            r_result   <= w_and;
            r_valid    <= 1'b1;
            r_zero     <= w_zero;
            r_all_ones <= w_all_ones;
            r_ones     <= w_ones;
        end else begin
            r_valid    <= 1'b0;
        end
    end

    assign result     = w_and;
    assign result_q   = r_result;
    assign out_valid  = r_valid;
    assign zero_q     = r_zero;
    assign all_ones_q = r_all_ones;
    assign ones_q     = r_ones;

`ifdef AND_TEST_STATS_EN
    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_zero_count;

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count   <= '0;
            r_zero_count <= '0;
        end else if (in_valid) begin
            if (r_op_count != '1) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
            if (w_zero && (r_zero_count != '1)) begin
                r_zero_count <= r_zero_count + CNT_W'(1);
            end
        end
    end

    assign op_count   = r_op_count;
    assign zero_count = r_zero_count;
`endif

endmodule

// File: tb/tb_and_test.sv
// Directed bench for and_test: combinational path, reset, registered path, back-to-back and stats.
// Stats checks are built only when AND_TEST_STATS_EN is defined.
module tb_and_test;
    localparam int WIDTH  = 4;
`ifdef AND_TEST_STATS_EN
    localparam int CNT_W  = 2;
`else
    localparam int CNT_W  = 16;
`endif
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic              clk = 1'b0;
    logic              clk_run = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              in_valid;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  result_q;
    logic              out_valid;
    logic              zero_q;
    logic              all_ones_q;
    logic [ONES_W-1:0] ones_q;
`ifdef AND_TEST_STATS_EN
    logic [CNT_W-1:0]  op_count;
    logic [CNT_W-1:0]  zero_count;
`endif

    int total = 0;
    int bad   = 0;

    and_test #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .result     (result),
        .result_q   (result_q),
        .out_valid  (out_valid),
        .zero_q     (zero_q),
        .all_ones_q (all_ones_q),
`ifdef AND_TEST_STATS_EN
        .op_count   (op_count),
        .zero_count (zero_count),
`endif
        .ones_q     (ones_q)
    );

    // Clock stays idle until the unclocked combinational checks are done.
    initial begin
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb();
        a = 4'b0001; b = 4'b0101; #10;
        total++; if (result !== 4'b0001) begin bad++; $display("FAIL comb_ref1 got=%b exp=0001", result); end
        a = 4'b1111; b = 4'b1101; #10;
        total++; if (result !== 4'b1101) begin bad++; $display("FAIL comb_ref2 got=%b exp=1101", result); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
        clk_run = 1'b1;
        tick(); tick();
        total++; if (result_q !== 4'b0000) begin bad++; $display("FAIL rst_result_q got=%b exp=0000", result_q); end
        total++; if (zero_q !== 1'b1) begin bad++; $display("FAIL rst_zero_q got=%b exp=1", zero_q); end
        total++; if (all_ones_q !== 1'b0) begin bad++; $display("FAIL rst_all_ones_q got=%b exp=0", all_ones_q); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (ones_q !== 3'd0) begin bad++; $display("FAIL rst_ones_q got=%0d exp=0", ones_q); end
        total++; if (result !== 4'b1111) begin bad++; $display("FAIL rst_comb_result got=%b exp=1111", result); end
`ifdef AND_TEST_STATS_EN
        total++; if (op_count !== 2'd0) begin bad++; $display("FAIL rst_op_count got=%0d exp=0", op_count); end
        total++; if (zero_count !== 2'd0) begin bad++; $display("FAIL rst_zero_count got=%0d exp=0", zero_count); end
`endif
    endtask

    task automatic test_registered();
        rst_n = 1'b1; in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
        tick();
        total++; if (result_q !== 4'b1111) begin bad++; $display("FAIL reg_result_q got=%b exp=1111", result_q); end
        total++; if (all_ones_q !== 1'b1) begin bad++; $display("FAIL reg_all_ones_q got=%b exp=1", all_ones_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL reg_zero_q got=%b exp=0", zero_q); end
        total++; if (ones_q !== 3'd4) begin bad++; $display("FAIL reg_ones_q got=%0d exp=4", ones_q); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL reg_out_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0; a = 4'b0000; b = 4'b0000;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_out_valid got=%b exp=0", out_valid); end
        total++; if (result_q !== 4'b1111) begin bad++; $display("FAIL hold_result_q got=%b exp=1111", result_q); end
        total++; if (ones_q !== 3'd4) begin bad++; $display("FAIL hold_ones_q got=%0d exp=4", ones_q); end
        total++; if (all_ones_q !== 1'b1) begin bad++; $display("FAIL hold_all_ones_q got=%b exp=1", all_ones_q); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; a = 4'b1010; b = 4'b0110;
        tick();
        total++; if (result_q !== 4'b0010) begin bad++; $display("FAIL b2b1_result_q got=%b exp=0010", result_q); end
        total++; if (ones_q !== 3'd1) begin bad++; $display("FAIL b2b1_ones_q got=%0d exp=1", ones_q); end
        total++; if (zero_q !== 1'b0) begin bad++; $display("FAIL b2b1_zero_q got=%b exp=0", zero_q); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b1_out_valid got=%b exp=1", out_valid); end
        a = 4'b0101; b = 4'b1010;
        tick();
        total++; if (result_q !== 4'b0000) begin bad++; $display("FAIL b2b2_result_q got=%b exp=0000", result_q); end
        total++; if (zero_q !== 1'b1) begin bad++; $display("FAIL b2b2_zero_q got=%b exp=1", zero_q); end
        total++; if (ones_q !== 3'd0) begin bad++; $display("FAIL b2b2_ones_q got=%0d exp=0", ones_q); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b2_out_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; a = 4'b1100; b = 4'b0100; rst_n = 1'b0;
        tick();
        total++; if (result_q !== 4'b0000) begin bad++; $display("FAIL mid_rst_result_q got=%b exp=0000", result_q); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1; a = 4'b0111; b = 4'b0011;
        tick();
        total++; if (result_q !== 4'b0011) begin bad++; $display("FAIL post_rst_result_q got=%b exp=0011", result_q); end
        total++; if (ones_q !== 3'd2) begin bad++; $display("FAIL post_rst_ones_q got=%0d exp=2", ones_q); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_rst_out_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

`ifdef AND_TEST_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0; in_valid = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b1;
        a = 4'b1111; b = 4'b1111; tick();
        a = 4'b0001; b = 4'b0010; tick();
        total++; if (op_count !== 2'd2) begin bad++; $display("FAIL stats_op_mid got=%0d exp=2", op_count); end
        total++; if (zero_count !== 2'd1) begin bad++; $display("FAIL stats_zero_mid got=%0d exp=1", zero_count); end
        a = 4'b0011; b = 4'b0011; tick();
        a = 4'b0100; b = 4'b1000; tick();
        a = 4'b0111; b = 4'b0111; tick();
        in_valid = 1'b0;
        tick();
        total++; if (op_count !== 2'd3) begin bad++; $display("FAIL stats_op_sat got=%0d exp=3", op_count); end
        total++; if (zero_count !== 2'd2) begin bad++; $display("FAIL stats_zero_end got=%0d exp=2", zero_count); end
        rst_n = 1'b0;
        tick();
        total++; if (op_count !== 2'd0) begin bad++; $display("FAIL stats_op_clr got=%0d exp=0", op_count); end
        total++; if (zero_count !== 2'd0) begin bad++; $display("FAIL stats_zero_clr got=%0d exp=0", zero_count); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        test_comb();
        test_reset();
        test_registered();
        test_back_to_back();
        test_reset_midstream();
`ifdef AND_TEST_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
